// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity selectors and prescale floor shared by the UART TX and RX sides
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} tx_state_e;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam int unsigned MIN_PRESCALE = 4;
endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: combinational even/odd parity of a data word
module uart_parity_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             par_typ,
  output logic             par
);
  import uart_pkg::*;
  assign par = (par_typ == PAR_ODD) ? ~^data : ^data;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART frame serialiser (start, LSB-first data, optional parity, stop bits)
// UART_TX_STOP2_EN adds the STOP2 port and an optional second stop bit.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int PRE_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRE_WIDTH-1:0]  Prescale,
`ifdef UART_TX_STOP2_EN
  input  logic                  STOP2,
`endif
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  TX_DONE
);
  import uart_pkg::*;
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
  localparam logic [PRE_WIDTH-1:0] MIN_PRE = PRE_WIDTH'(MIN_PRESCALE);
  tx_state_e state, state_n;
  logic [PRE_WIDTH-1:0] cnt, cnt_n, pre_r;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_WIDTH-1:0] data_r;
  logic par_en_r, par_typ_r, par, bit_end, last_n, tx_n, busy_n, done_n;
`ifdef UART_TX_STOP2_EN
  logic stop2_r;
`endif
  uart_parity_calc #(.WIDTH(DATA_WIDTH)) u_par (.data(data_r), .par_typ(par_typ_r), .par(par));
  assign bit_end = cnt == pre_r - 1'b1;
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = bit_end ? '0 : cnt + 1'b1;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (Data_Valid) state_n = START;
      end
      START: if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        idx_n = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        if (idx == LAST_IDX) state_n = par_en_r ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_n = STOP;
`ifdef UART_TX_STOP2_EN
      STOP: if (bit_end) state_n = stop2_r ? uart_pkg::STOP2 : IDLE;
      uart_pkg::STOP2: if (bit_end) state_n = IDLE;
`else
      STOP: if (bit_end) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
`ifdef UART_TX_STOP2_EN
    last_n = (state_n == STOP && !stop2_r) || state_n == uart_pkg::STOP2;
`else
    last_n = state_n == STOP;
`endif
    // outputs are computed from the next state so they can be registered with no lag
    tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? data_r[idx_n] : (state_n == PARITY) ? par : 1'b1;
    busy_n = state_n != IDLE;
    done_n = last_n && cnt_n == pre_r - 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      data_r <= '0;
      pre_r <= '0;
      par_en_r <= 1'b0;
      par_typ_r <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop2_r <= 1'b0;
`endif
      TX_OUT <= 1'b1;
      busy <= 1'b0;
      TX_DONE <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      TX_OUT <= tx_n;
      busy <= busy_n;
      TX_DONE <= done_n;
      if (state == IDLE && Data_Valid) begin
        data_r <= P_DATA;
        pre_r <= (Prescale < MIN_PRE) ? MIN_PRE : Prescale;
        par_en_r <= PAR_EN;
        par_typ_r <= PAR_TYP;
`ifdef UART_TX_STOP2_EN
        stop2_r <= STOP2;
`endif
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: table-driven frame checks plus back-to-back and mid-frame reset sequences
module tb_uart_tx_frame;
  logic clk = 1'b0;
  logic rst, dv, pe, pt, tx, busy, done;
  logic [7:0] pd;
  logic [4:0] pre;
`ifdef UART_TX_STOP2_EN
  logic stop2;
`endif
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] d;
    logic pe, pt;
    logic [4:0] pre;
    logic s2;
    int eff;
    logic par;
    int len;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  uart_tx_frame dut (
    .CLK(clk), .RST(rst), .P_DATA(pd), .Data_Valid(dv), .PAR_EN(pe), .PAR_TYP(pt), .Prescale(pre),
`ifdef UART_TX_STOP2_EN
    .STOP2(stop2),
`endif
    .TX_OUT(tx), .busy(busy), .TX_DONE(done)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic idle_chk(input string name);
    chk({name, " tx"}, int'(tx), 1);
    chk({name, " busy"}, int'(busy), 0);
    chk({name, " done"}, int'(done), 0);
  endtask
  task automatic start_frame(input logic [7:0] d, input logic e, input logic t, input logic [4:0] p, input logic s2);
    pd = d; pe = e; pt = t; pre = p; dv = 1'b1;
`ifdef UART_TX_STOP2_EN
    stop2 = s2;
`else
    if (s2) $display("note: stop2 row ignored without UART_TX_STOP2_EN");
`endif
    @(negedge clk);
    dv = 1'b0;
    pd = ~d; pt = ~t; pe = ~e; pre = p + 5'd3;
  endtask
  task automatic check_frame(input string name, input logic [7:0] d, input logic e, input logic par, input int eff, input int len);
    logic [11:0] b;
    int bi;
    b = '1;
    b[0] = 1'b0;
    b[8:1] = d;
    if (e) b[9] = par;
    for (int c = 1; c <= len; c++) begin
      bi = (c - 1) / eff;
      chk({name, " tx"}, int'(tx), bi < 12 ? int'(b[bi]) : 1);
      chk({name, " busy"}, int'(busy), 1);
      chk({name, " done"}, int'(done), c == len ? 1 : 0);
      @(negedge clk);
    end
    idle_chk({name, " end"});
  endtask
  initial begin
    rst = 1'b1; dv = 1'b0; pd = '0; pe = 1'b0; pt = 1'b0; pre = 5'd8;
`ifdef UART_TX_STOP2_EN
    stop2 = 1'b0;
`endif
    tbl.push_back('{8'hA5, 1'b0, 1'b0, 5'd8, 1'b0, 8, 1'b0, 80});
    tbl.push_back('{8'h07, 1'b1, 1'b0, 5'd16, 1'b0, 16, 1'b1, 176});
    tbl.push_back('{8'h07, 1'b1, 1'b1, 5'd16, 1'b0, 16, 1'b0, 176});
    tbl.push_back('{8'h5A, 1'b1, 1'b0, 5'd4, 1'b0, 4, 1'b0, 44});
    tbl.push_back('{8'h80, 1'b0, 1'b0, 5'd2, 1'b0, 4, 1'b0, 40});
    tbl.push_back('{8'hC3, 1'b1, 1'b1, 5'd31, 1'b0, 31, 1'b1, 341});
    tbl.push_back('{8'h01, 1'b0, 1'b0, 5'd0, 1'b0, 4, 1'b0, 40});
`ifdef UART_TX_STOP2_EN
    tbl.push_back('{8'hA5, 1'b0, 1'b0, 5'd8, 1'b1, 8, 1'b0, 88});
    tbl.push_back('{8'h03, 1'b1, 1'b0, 5'd2, 1'b1, 4, 1'b0, 48});
`endif
    repeat (2) @(negedge clk);
    idle_chk("reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      idle_chk("idle");
    end
    foreach (tbl[i]) begin
      start_frame(tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].pre, tbl[i].s2);
      check_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].pe, tbl[i].par, tbl[i].eff, tbl[i].len);
      @(negedge clk);
    end
    // Data_Valid held through the frame: second byte waits for the idle cycle
    pd = 8'h3C; pe = 1'b0; pt = 1'b0; pre = 5'd8; dv = 1'b1;
`ifdef UART_TX_STOP2_EN
    stop2 = 1'b0;
`endif
    @(negedge clk);
    pd = 8'hFF;
    check_frame("b2b first", 8'h3C, 1'b0, 1'b0, 8, 80);
    @(negedge clk);
    dv = 1'b0;
    check_frame("b2b second", 8'hFF, 1'b0, 1'b0, 8, 80);
    @(negedge clk);
    start_frame(8'hF0, 1'b0, 1'b0, 5'd8, 1'b0);
    repeat (34) @(negedge clk);
    chk("pre-abort tx", int'(tx), 0);
    chk("pre-abort busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_chk("abort");
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      idle_chk("post-abort");
    end
    start_frame(8'hF0, 1'b0, 1'b0, 5'd8, 1'b0);
    check_frame("clean", 8'hF0, 1'b0, 1'b0, 8, 80);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
